// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage.
//  mem_state_t : handshake FSM states (IDLE / MEM / RX / TX)
//  BR_*        : branch codes carried on ex_branch
//  ex_mem_t    : EX/MEM pipeline latch contents
// PC-like fields are stored at PC_MAX_WIDTH bits so the struct does not depend on the
// INST_MEM_WIDTH parameter of the instantiating module.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        RX,
        TX
    } mem_state_t;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JUMP = 2'b11;

    localparam int unsigned PC_MAX_WIDTH = 26;

    typedef struct packed {
        logic                    valid;
        logic                    distinct;
        logic                    regwrite;
        logic                    memwrite;
        logic                    memread;
        logic                    uarttoreg;
        logic                    regtouart;
        logic [1:0]              memtoreg;
        logic [1:0]              branch;
        logic [31:0]             alu_result;
        logic [31:0]             reg_data;
        logic [4:0]              rdist;
        logic [25:0]             inst_index;
        logic [PC_MAX_WIDTH-1:0] pc1;
        logic [PC_MAX_WIDTH-1:0] pc2;
    } ex_mem_t;

    // True when the op needs the memory or UART handshake.
    function automatic logic is_access(ex_mem_t e);
        return e.memread | e.memwrite | e.uarttoreg | e.regtouart;
    endfunction

    function automatic logic branch_cond(logic [1:0] br, logic distinct);
        logic taken;
        unique case (br)
            BR_NONE: taken = 1'b0;
            BR_BEQ:  taken = ~distinct;
            BR_BNE:  taken = distinct;
            BR_JUMP: taken = 1'b1;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/mem_handshake_fsm.sv
// Handshake sequencer for the memory-access stage.
// The next state is chosen from the EX inputs at the capture edge, so an access begins
// the cycle after capture with the request already driven from the latch.
// Ports:
//  clk, rstn                      clock, async active-low reset
//  ex_valid, ex_memread, ex_memwrite, ex_uarttoreg, ex_regtouart
//                                 op being captured this edge (used only while idle)
//  lat_memwrite                   latched store flag (drives dmem_we)
//  dmem_ready, uart_rx_valid, uart_tx_ready   completion inputs
//  stall                          state != IDLE
//  done                           handshake completes this cycle
//  dmem_req, dmem_we, uart_rx_ack, uart_tx_valid   request / ack outputs
module mem_handshake_fsm
    import mem_access_stage_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic ex_valid,
    input  logic ex_memread,
    input  logic ex_memwrite,
    input  logic ex_uarttoreg,
    input  logic ex_regtouart,
    input  logic lat_memwrite,
    input  logic dmem_ready,
    input  logic uart_rx_valid,
    input  logic uart_tx_ready,
    output logic stall,
    output logic done,
    output logic dmem_req,
    output logic dmem_we,
    output logic uart_rx_ack,
    output logic uart_tx_valid
);

    mem_state_t state_q, state_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                // MEM has priority over RX, RX over TX.
                if (ex_valid) begin
                    if (ex_memread | ex_memwrite) begin
                        state_d = MEM;
                    end else if (ex_uarttoreg) begin
                        state_d = RX;
                    end else if (ex_regtouart) begin
                        state_d = TX;
                    end
                end
            end
            MEM: if (dmem_ready)    state_d = IDLE;
            RX:  if (uart_rx_valid) state_d = IDLE;
            TX:  if (uart_tx_ready) state_d = IDLE;
        endcase
    end

    always_comb begin
        stall         = 1'b0;
        done          = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        uart_rx_ack   = 1'b0;
        uart_tx_valid = 1'b0;
        unique case (state_q)
            IDLE: ;
            MEM: begin
                stall    = 1'b1;
                dmem_req = 1'b1;
                dmem_we  = lat_memwrite;
                done     = dmem_ready;
            end
            RX: begin
                stall       = 1'b1;
                uart_rx_ack = uart_rx_valid;
                done        = uart_rx_valid;
            end
            TX: begin
                stall         = 1'b1;
                uart_tx_valid = 1'b1;
                done          = uart_tx_ready;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register plus memory-access stage.
// Latches EX results when not stalled, runs a data-memory or UART handshake for access
// ops, resolves branches and registers MEM/WB results.
// Optional feature macro: MEM_ACCESS_FWD_EN adds fwd_valid / fwd_rdist / fwd_data, a
// combinational view of the latched plain-op result for forwarding.
// Ports:
//  clk, rstn                  clock, async active-low reset
//  ex_*                       EX-stage results and controls
//  stall                      upstream must hold
//  dmem_req/we/addr/wdata, dmem_ready/rdata          data-memory handshake
//  uart_rx_valid/data, uart_rx_ack                   UART receive
//  uart_tx_valid/data, uart_tx_ready                 UART transmit
//  br_taken, br_target        one-cycle redirect
//  wb_valid, wb_regwrite, wb_memtoreg, wb_rdist, wb_alu_result, wb_mem_data, wb_pc1
//                             registered writeback
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned INST_MEM_WIDTH = 2,
    parameter int unsigned DMEM_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      ex_valid,
    input  logic                      ex_distinct,
    input  logic                      ex_regwrite,
    input  logic                      ex_memwrite,
    input  logic                      ex_memread,
    input  logic                      ex_uarttoreg,
    input  logic                      ex_regtouart,
    input  logic [1:0]                ex_memtoreg,
    input  logic [1:0]                ex_branch,
    input  logic [31:0]               ex_alu_result,
    input  logic [31:0]               ex_reg_data,
    input  logic [4:0]                ex_rdist,
    input  logic [25:0]               ex_inst_index,
    input  logic [INST_MEM_WIDTH-1:0] ex_pc1,
    input  logic [INST_MEM_WIDTH-1:0] ex_pc2,
    output logic                      stall,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [DMEM_WIDTH-1:0]     dmem_addr,
    output logic [31:0]               dmem_wdata,
    input  logic                      dmem_ready,
    input  logic [31:0]               dmem_rdata,
    input  logic                      uart_rx_valid,
    input  logic [7:0]                uart_rx_data,
    output logic                      uart_rx_ack,
    output logic                      uart_tx_valid,
    output logic [7:0]                uart_tx_data,
    input  logic                      uart_tx_ready,
    output logic                      br_taken,
    output logic [INST_MEM_WIDTH-1:0] br_target,
    output logic                      wb_valid,
    output logic                      wb_regwrite,
    output logic [1:0]                wb_memtoreg,
    output logic [4:0]                wb_rdist,
    output logic [31:0]               wb_alu_result,
    output logic [31:0]               wb_mem_data,
    output logic [INST_MEM_WIDTH-1:0] wb_pc1
`ifdef MEM_ACCESS_FWD_EN
    ,
    output logic                      fwd_valid,
    output logic [4:0]                fwd_rdist,
    output logic [31:0]               fwd_data
`endif
);

    ex_mem_t ex_in, lat_q;

    always_comb begin
        ex_in            = '0;
        ex_in.valid      = ex_valid;
        ex_in.distinct   = ex_distinct;
        ex_in.regwrite   = ex_regwrite;
        ex_in.memwrite   = ex_memwrite;
        ex_in.memread    = ex_memread;
        ex_in.uarttoreg  = ex_uarttoreg;
        ex_in.regtouart  = ex_regtouart;
        ex_in.memtoreg   = ex_memtoreg;
        ex_in.branch     = ex_branch;
        ex_in.alu_result = ex_alu_result;
        ex_in.reg_data   = ex_reg_data;
        ex_in.rdist      = ex_rdist;
        ex_in.inst_index = ex_inst_index;
        ex_in.pc1        = PC_MAX_WIDTH'(ex_pc1);
        ex_in.pc2        = PC_MAX_WIDTH'(ex_pc2);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_q <= '0;
        end else if (!stall) begin
            lat_q <= ex_in;
        end
    end

    logic done;

    mem_handshake_fsm u_fsm (
        .clk           (clk),
        .rstn          (rstn),
        .ex_valid      (ex_valid),
        .ex_memread    (ex_memread),
        .ex_memwrite   (ex_memwrite),
        .ex_uarttoreg  (ex_uarttoreg),
        .ex_regtouart  (ex_regtouart),
        .lat_memwrite  (lat_q.memwrite),
        .dmem_ready    (dmem_ready),
        .uart_rx_valid (uart_rx_valid),
        .uart_tx_ready (uart_tx_ready),
        .stall         (stall),
        .done          (done),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .uart_rx_ack   (uart_rx_ack),
        .uart_tx_valid (uart_tx_valid)
    );

    assign dmem_addr    = dmem_req ? lat_q.alu_result[DMEM_WIDTH-1:0] : '0;
    assign dmem_wdata   = dmem_req ? lat_q.reg_data : '0;
    assign uart_tx_data = uart_tx_valid ? lat_q.reg_data[7:0] : '0;

    // A latched access op seen while idle has already completed, so only plain ops issue
    // from the idle state; access ops issue on their completion cycle instead.
    logic                      issue;
    logic                      wb_fire;
    logic                      ld_update;
    logic [31:0]               ld_data;
    logic                      br_fire;
    logic [INST_MEM_WIDTH-1:0] br_target_d;

    always_comb begin
        issue       = !stall && lat_q.valid && !is_access(lat_q);
        wb_fire     = issue || done;
        ld_update   = uart_rx_ack || (done && dmem_req && lat_q.memread);
        ld_data     = uart_rx_ack ? {24'b0, uart_rx_data} : dmem_rdata;
        br_fire     = issue && branch_cond(lat_q.branch, lat_q.distinct);
        br_target_d = (lat_q.branch == BR_JUMP) ? lat_q.inst_index[INST_MEM_WIDTH-1:0]
                                                : lat_q.pc2[INST_MEM_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_valid      <= 1'b0;
            wb_regwrite   <= 1'b0;
            wb_memtoreg   <= '0;
            wb_rdist      <= '0;
            wb_alu_result <= '0;
            wb_mem_data   <= '0;
            wb_pc1        <= '0;
            br_taken      <= 1'b0;
            br_target     <= '0;
        end else begin
            wb_valid    <= wb_fire;
            wb_regwrite <= wb_fire && lat_q.regwrite;
            br_taken    <= br_fire;
            if (wb_fire) begin
                wb_memtoreg   <= lat_q.memtoreg;
                wb_rdist      <= lat_q.rdist;
                wb_alu_result <= lat_q.alu_result;
                wb_pc1        <= lat_q.pc1[INST_MEM_WIDTH-1:0];
            end
            if (ld_update) begin
                wb_mem_data <= ld_data;
            end
            if (br_fire) begin
                br_target <= br_target_d;
            end
        end
    end

    // Upper PC / index bits are stored for a generic latch but never consumed here.
    logic unused_lat_bits;
    assign unused_lat_bits = ^{lat_q.inst_index, lat_q.pc1, lat_q.pc2};

`ifdef MEM_ACCESS_FWD_EN
    always_comb begin
        fwd_valid = issue && lat_q.regwrite && (lat_q.rdist != 5'd0);
        fwd_rdist = fwd_valid ? lat_q.rdist : '0;
        fwd_data  = fwd_valid ? lat_q.alu_result : '0;
    end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int unsigned IW = 2;
    localparam int unsigned DW = 16;

    logic          clk, rstn;
    logic          ex_valid, ex_distinct, ex_regwrite, ex_memwrite, ex_memread;
    logic          ex_uarttoreg, ex_regtouart;
    logic [1:0]    ex_memtoreg, ex_branch;
    logic [31:0]   ex_alu_result, ex_reg_data;
    logic [4:0]    ex_rdist;
    logic [25:0]   ex_inst_index;
    logic [IW-1:0] ex_pc1, ex_pc2;
    logic          stall, dmem_req, dmem_we, dmem_ready;
    logic [DW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata, dmem_rdata;
    logic          uart_rx_valid, uart_rx_ack, uart_tx_valid, uart_tx_ready;
    logic [7:0]    uart_rx_data, uart_tx_data;
    logic          br_taken, wb_valid, wb_regwrite;
    logic [IW-1:0] br_target, wb_pc1;
    logic [1:0]    wb_memtoreg;
    logic [4:0]    wb_rdist;
    logic [31:0]   wb_alu_result, wb_mem_data;
`ifdef MEM_ACCESS_FWD_EN
    logic          fwd_valid;
    logic [4:0]    fwd_rdist;
    logic [31:0]   fwd_data;
`endif

    mem_access_stage #(
        .INST_MEM_WIDTH (IW),
        .DMEM_WIDTH     (DW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .ex_valid      (ex_valid),
        .ex_distinct   (ex_distinct),
        .ex_regwrite   (ex_regwrite),
        .ex_memwrite   (ex_memwrite),
        .ex_memread    (ex_memread),
        .ex_uarttoreg  (ex_uarttoreg),
        .ex_regtouart  (ex_regtouart),
        .ex_memtoreg   (ex_memtoreg),
        .ex_branch     (ex_branch),
        .ex_alu_result (ex_alu_result),
        .ex_reg_data   (ex_reg_data),
        .ex_rdist      (ex_rdist),
        .ex_inst_index (ex_inst_index),
        .ex_pc1        (ex_pc1),
        .ex_pc2        (ex_pc2),
        .stall         (stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ready    (dmem_ready),
        .dmem_rdata    (dmem_rdata),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_ack   (uart_rx_ack),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_ready (uart_tx_ready),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .wb_valid      (wb_valid),
        .wb_regwrite   (wb_regwrite),
        .wb_memtoreg   (wb_memtoreg),
        .wb_rdist      (wb_rdist),
        .wb_alu_result (wb_alu_result),
        .wb_mem_data   (wb_mem_data),
        .wb_pc1        (wb_pc1)
`ifdef MEM_ACCESS_FWD_EN
        ,
        .fwd_valid     (fwd_valid),
        .fwd_rdist     (fwd_rdist),
        .fwd_data      (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit        valid;
        bit        distinct;
        bit        regwrite;
        bit        memwrite;
        bit        memread;
        bit        uarttoreg;
        bit        regtouart;
        bit [1:0]  memtoreg;
        bit [1:0]  branch;
        bit [31:0] alu;
        bit [31:0] wdata;
        bit [4:0]  rdist;
        bit [25:0] idx;
        bit [1:0]  pc1;
        bit [1:0]  pc2;
    } op_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] mem_data_exp = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // 0 plain, 1 data memory, 2 uart rx, 3 uart tx (memory beats rx beats tx)
    function automatic int kind_of(op_t o);
        if (o.memread || o.memwrite) return 1;
        if (o.uarttoreg) return 2;
        if (o.regtouart) return 3;
        return 0;
    endfunction

    function automatic op_t base_op();
        op_t o = '0;
        o.valid = 1'b1;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o = base_op();
        int  k = $urandom_range(0, 4);
        o.distinct = 1'($urandom);
        o.regwrite = 1'($urandom);
        o.memtoreg = 2'($urandom);
        o.alu      = $urandom;
        o.wdata    = $urandom;
        o.rdist    = 5'($urandom);
        o.idx      = 26'($urandom);
        o.pc1      = 2'($urandom);
        o.pc2      = 2'($urandom);
        o.memread   = (k == 1);
        o.memwrite  = (k == 2);
        o.uarttoreg = (k == 3);
        o.regtouart = (k == 4);
        if (k != 0 && $urandom_range(0, 3) == 0) begin
            o.uarttoreg = o.uarttoreg | 1'($urandom);
            o.regtouart = o.regtouart | 1'($urandom);
        end
        if (k == 0) o.branch = 2'($urandom);
        return o;
    endfunction

    task automatic drive_ex(input op_t o);
        ex_valid      = o.valid;
        ex_distinct   = o.distinct;
        ex_regwrite   = o.regwrite;
        ex_memwrite   = o.memwrite;
        ex_memread    = o.memread;
        ex_uarttoreg  = o.uarttoreg;
        ex_regtouart  = o.regtouart;
        ex_memtoreg   = o.memtoreg;
        ex_branch     = o.branch;
        ex_alu_result = o.alu;
        ex_reg_data   = o.wdata;
        ex_rdist      = o.rdist;
        ex_inst_index = o.idx;
        ex_pc1        = o.pc1;
        ex_pc2        = o.pc2;
    endtask

    // Random payload; valid=0 gives a bubble, valid=1 gives an op that must be ignored.
    task automatic drive_junk(input bit valid);
        op_t o = rand_op();
        o.valid = valid;
        drive_ex(o);
    endtask

    task automatic run_op(input op_t o, input int lat, input logic [31:0] rdata);
        int       k = kind_of(o);
        bit       taken = 1'b0;
        bit [1:0] tgt = o.pc2;
        @(negedge clk);
        check_eq("idle_stall", stall, 0);
        drive_ex(o);
        @(posedge clk);
        @(negedge clk);
        if (k != 0) begin
            for (int n = 1; n <= lat; n++) begin
                drive_junk(1'b1);
                dmem_ready    = (k == 1 && n == lat);
                dmem_rdata    = rdata;
                uart_rx_valid = (k == 2 && n == lat);
                uart_rx_data  = rdata[7:0];
                uart_tx_ready = (k == 3 && n == lat);
                #1;
                check_eq("busy_stall", stall, 1);
                check_eq("dmem_req", dmem_req, k == 1);
                check_eq("dmem_we", dmem_we, k == 1 && o.memwrite);
                if (k == 1) begin
                    check_eq("dmem_addr", dmem_addr, o.alu[15:0]);
                    check_eq("dmem_wdata", dmem_wdata, o.wdata);
                end
                check_eq("rx_ack", uart_rx_ack, k == 2 && n == lat);
                check_eq("tx_valid", uart_tx_valid, k == 3);
                if (k == 3) check_eq("tx_data", uart_tx_data, o.wdata[7:0]);
                check_eq("busy_wb_valid", wb_valid, 0);
`ifdef MEM_ACCESS_FWD_EN
                check_eq("busy_fwd_valid", fwd_valid, 0);
`endif
                @(posedge clk);
                @(negedge clk);
            end
            dmem_ready    = 1'b0;
            uart_rx_valid = 1'b0;
            uart_tx_ready = 1'b0;
            if (k == 1 && o.memread) mem_data_exp = rdata;
            if (k == 2) mem_data_exp = {24'b0, rdata[7:0]};
        end else begin
            drive_junk(1'b0);
            #1;
            check_eq("plain_stall", stall, 0);
            check_eq("early_wb_valid", wb_valid, 0);
`ifdef MEM_ACCESS_FWD_EN
            check_eq("fwd_valid", fwd_valid, o.regwrite && o.rdist != 0);
            if (o.regwrite && o.rdist != 0) begin
                check_eq("fwd_rdist", fwd_rdist, o.rdist);
                check_eq("fwd_data", fwd_data, o.alu);
            end
`endif
            @(posedge clk);
            @(negedge clk);
            case (o.branch)
                2'b01: taken = !o.distinct;
                2'b10: taken = o.distinct;
                2'b11: taken = 1'b1;
                default: taken = 1'b0;
            endcase
            if (o.branch == 2'b11) tgt = o.idx[1:0];
        end
        drive_junk(1'b0);
        check_eq("done_stall", stall, 0);
        check_eq("wb_valid", wb_valid, 1);
        check_eq("wb_regwrite", wb_regwrite, o.regwrite);
        check_eq("wb_memtoreg", wb_memtoreg, o.memtoreg);
        check_eq("wb_rdist", wb_rdist, o.rdist);
        check_eq("wb_alu_result", wb_alu_result, o.alu);
        check_eq("wb_pc1", wb_pc1, o.pc1);
        check_eq("wb_mem_data", wb_mem_data, mem_data_exp);
        check_eq("br_taken", br_taken, taken);
        if (taken) check_eq("br_target", br_target, tgt);
        @(posedge clk);
        @(negedge clk);
        check_eq("wb_valid_pulse", wb_valid, 0);
        check_eq("wb_regwrite_idle", wb_regwrite, 0);
        check_eq("br_taken_pulse", br_taken, 0);
    endtask

    initial begin
        op_t o;
        rstn          = 1'b0;
        dmem_ready    = 1'b0;
        dmem_rdata    = '0;
        uart_rx_valid = 1'b0;
        uart_rx_data  = '0;
        uart_tx_ready = 1'b0;
        drive_junk(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_dmem_req", dmem_req, 0);
        check_eq("rst_tx_valid", uart_tx_valid, 0);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_br_taken", br_taken, 0);
        check_eq("rst_wb_mem_data", wb_mem_data, 0);
        drive_junk(1'b0);
        rstn = 1'b1;

        // Load 0x10, ready on the third request cycle.
        o = base_op(); o.memread = 1'b1; o.regwrite = 1'b1; o.alu = 32'h10; o.rdist = 5'd3;
        run_op(o, 3, 32'hDEADBEEF);
        // Store, single-cycle access.
        o = base_op(); o.memwrite = 1'b1; o.alu = 32'h4; o.wdata = 32'h12345678;
        run_op(o, 1, 32'hFFFF0000);
        // UART receive after 5 cycles.
        o = base_op(); o.uarttoreg = 1'b1; o.regwrite = 1'b1; o.rdist = 5'd9;
        run_op(o, 5, 32'hABCDEF41);
        // UART transmit.
        o = base_op(); o.regtouart = 1'b1; o.wdata = 32'h0000005A;
        run_op(o, 2, 32'h0);
        // beq taken, bne not taken, jump.
        o = base_op(); o.branch = 2'b01; o.pc2 = 2'd2; o.pc1 = 2'd1;
        run_op(o, 1, 32'h0);
        o.branch = 2'b10;
        run_op(o, 1, 32'h0);
        o = base_op(); o.branch = 2'b11; o.idx = 26'd3; o.pc2 = 2'd1;
        run_op(o, 1, 32'h0);
        // addi r5 = 7, then same to r0.
        o = base_op(); o.regwrite = 1'b1; o.rdist = 5'd5; o.alu = 32'd7;
        run_op(o, 1, 32'h0);
        o.rdist = 5'd0;
        run_op(o, 1, 32'h0);

        // Reset during a pending load.
        o = base_op(); o.memread = 1'b1; o.alu = 32'h20;
        @(negedge clk);
        drive_ex(o);
        @(posedge clk);
        @(negedge clk);
        drive_junk(1'b1);
        #1;
        check_eq("pre_rst_req", dmem_req, 1);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_req", dmem_req, 0);
        check_eq("mid_rst_stall", stall, 0);
        check_eq("mid_rst_wb_valid", wb_valid, 0);
        check_eq("mid_rst_addr", dmem_addr, 0);
        mem_data_exp = '0;
        @(negedge clk);
        drive_junk(1'b0);
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("post_rst_stall", stall, 0);
        check_eq("post_rst_wb_valid", wb_valid, 0);
        check_eq("post_rst_br", br_taken, 0);
        check_eq("post_rst_mem_data", wb_mem_data, 0);

        for (int i = 0; i < 80; i++) begin
            run_op(rand_op(), $urandom_range(1, 4), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
